// File: rtl/tod_stream_checker.sv
// Checks a 96-bit time-of-day stream for format errors, bad increments, second jumps and loss of stream.
// Tracks lock state, emits a PPS pulse on second rollover and reports status through an Avalon-MM CSR block.
module tod_stream_checker #(
  parameter logic [31:0] MAX_STEP   = 32'h000A_0000,
  parameter int          LOCK_COUNT = 8,
  parameter int          TIMEOUT    = 1023,
  parameter int          PPS_WIDTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [95:0] tod_tdata,
  input  logic        tod_tvalid,
  input  logic [3:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        csr_readdatavalid,
  output logic        csr_waitrequest,
  output logic        pps_out,
  output logic        tod_err_irq
);

  typedef enum logic [1:0] {SEEK = 2'd0, ACQ = 2'd1, LOCKED = 2'd2} state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(PPS_WIDTH + 1);
  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  state_t state, next_state;

  logic          s_valid;
  logic [47:0]   s_sec, prev_sec, snap_sec;
  logic [31:0]   s_ns, prev_ns, snap_ns;
  logic [15:0]   s_fns, prev_fns, snap_fns;
  logic [47:0]   delta;
  logic [GW-1:0] good_cnt;
  logic [IW-1:0] idle_cnt;
  logic [PW-1:0] pps_cnt;
  logic [3:0]    err_status, irq_en, new_err, w1c_mask;
  logic [15:0]   err_count;
  logic [31:0]   pps_count, rd_mux;
  logic          snap_req, clr_req;
  logic          same_sec, next_sec, checking, timeout;
  logic          fmt_err, jump_err, step_err, sample_err, sample_good, pps_trig;
  logic          unused_wdata;

  assign unused_wdata    = ^csr_writedata[31:4];
  assign csr_waitrequest = 1'b0;
  assign pps_out         = (pps_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_sec   <= '0;
      s_ns    <= '0;
      s_fns   <= '0;
    end else begin
      s_valid <= tod_tvalid;
      if (tod_tvalid) begin
        s_sec <= tod_tdata[95:48];
        s_ns  <= tod_tdata[47:16];
        s_fns <= tod_tdata[15:0];
      end
    end
  end

  // Delta is only meaningful when the sample stays in, or advances by exactly one, second.
  always_comb begin
    same_sec    = (s_sec == prev_sec);
    next_sec    = (s_sec == prev_sec + 48'd1);
    if (next_sec)
      delta = {s_ns, s_fns} + {NS_PER_SEC, 16'h0} - {prev_ns, prev_fns};
    else
      delta = {s_ns, s_fns} - {prev_ns, prev_fns};
    timeout     = (state != SEEK) && !tod_tvalid && (idle_cnt == IW'(TIMEOUT - 1));
    checking    = s_valid && (state != SEEK) && !timeout;
    fmt_err     = checking && (s_ns >= NS_PER_SEC);
    jump_err    = checking && !fmt_err && !same_sec && !next_sec;
    step_err    = checking && !fmt_err && (same_sec || next_sec) &&
                  ((delta == '0) || (delta > {16'h0, MAX_STEP}));
    sample_err  = fmt_err || jump_err || step_err;
    sample_good = checking && !sample_err;
    pps_trig    = sample_good && next_sec;
    new_err     = {timeout, jump_err, step_err, fmt_err};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SEEK;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SEEK:    if (s_valid) next_state = ACQ;
      ACQ: begin
        if (timeout)                                      next_state = SEEK;
        else if (sample_good && good_cnt == GW'(LOCK_COUNT - 1)) next_state = LOCKED;
      end
      LOCKED: begin
        if (timeout)         next_state = SEEK;
        else if (sample_err) next_state = ACQ;
      end
      default: next_state = SEEK;
    endcase
  end

  // A FMT sample leaves prev alone; JUMP and STEP samples still become the new reference.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sec <= '0;
      prev_ns  <= '0;
      prev_fns <= '0;
      good_cnt <= '0;
      idle_cnt <= '0;
      pps_cnt  <= '0;
    end else begin
      if (s_valid && (state == SEEK || (checking && !fmt_err))) begin
        prev_sec <= s_sec;
        prev_ns  <= s_ns;
        prev_fns <= s_fns;
      end
      if (state == SEEK || sample_err || timeout) good_cnt <= '0;
      else if (sample_good && state == ACQ)       good_cnt <= good_cnt + GW'(1);
      if (state == SEEK || tod_tvalid || timeout) idle_cnt <= '0;
      else                                        idle_cnt <= idle_cnt + IW'(1);
      if (pps_trig)            pps_cnt <= PW'(PPS_WIDTH);
      else if (pps_cnt != '0)  pps_cnt <= pps_cnt - PW'(1);
    end
  end

  assign w1c_mask = (csr_write && csr_address == 4'h1) ? csr_writedata[3:0] : 4'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_status  <= '0;
      irq_en      <= '0;
      snap_req    <= 1'b0;
      clr_req     <= 1'b0;
      snap_sec    <= '0;
      snap_ns     <= '0;
      snap_fns    <= '0;
      err_count   <= '0;
      pps_count   <= '0;
      tod_err_irq <= 1'b0;
    end else begin
      err_status  <= (err_status & ~w1c_mask) | new_err;
      if (csr_write && csr_address == 4'h2) irq_en <= csr_writedata[3:0];
      snap_req    <= csr_write && (csr_address == 4'h3) && csr_writedata[0];
      clr_req     <= csr_write && (csr_address == 4'h3) && csr_writedata[1];
      if (snap_req) begin
        snap_sec <= prev_sec;
        snap_ns  <= prev_ns;
        snap_fns <= prev_fns;
      end
      if (clr_req)                                            err_count <= '0;
      else if ((sample_err || timeout) && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (clr_req)       pps_count <= '0;
      else if (pps_trig) pps_count <= pps_count + 32'd1;
      tod_err_irq <= |(err_status & irq_en);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      4'h0: rd_mux = {30'd0, state};
      4'h1: rd_mux = {28'd0, err_status};
      4'h2: rd_mux = {28'd0, irq_en};
      4'h4: rd_mux = {16'd0, snap_sec[47:32]};
      4'h5: rd_mux = snap_sec[31:0];
      4'h6: rd_mux = snap_ns;
      4'h7: rd_mux = {16'd0, snap_fns};
      4'h8: rd_mux = {16'd0, err_count};
      4'h9: rd_mux = pps_count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csr_readdatavalid <= 1'b0;
      csr_readdata      <= '0;
    end else begin
      csr_readdatavalid <= csr_read;
      csr_readdata      <= csr_read ? rd_mux : 32'd0;
    end
  end

endmodule
